// File: rtl/bch_decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bch_decode_sequencer
// Description : Bit-serial BCH(15,7,t=2) encoder / syndrome, locator and Chien
//               search decoder behind a valid/ready job interface.
//               Optional macro BCH_ERR_COUNT_EN enables the err_cnt counter.
// Revision    : 1.0 - initial release
// ============================================================================
module bch_decode_sequencer #(
  parameter logic [8:0] GEN_POLY = 9'b111010001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [14:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] out_data,
  output logic [1:0]  out_status,
  output logic [7:0]  err_cnt
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_ENC    = 3'd1;
  localparam logic [2:0] c_SYND   = 3'd2;
  localparam logic [2:0] c_LOCATE = 3'd3;
  localparam logic [2:0] c_CHIEN  = 3'd4;
  localparam logic [2:0] c_DONE   = 3'd5;

  // GF(16) constants, field polynomial x^4+x+1
  localparam logic [3:0] c_ALPHA      = 4'b0010;
  localparam logic [3:0] c_ALPHA3     = 4'b1000;
  localparam logic [3:0] c_ALPHA_INV  = 4'b1001;
  localparam logic [3:0] c_ALPHA_INV2 = 4'b1101;

  localparam logic [1:0] c_ST_UNCORR = 2'b11;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'd0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'b0011 : 4'b0000);
    end
    return acc;
  endfunction

  // Inverse as a^14 = a^8 * a^4 * a^2; maps 0 to 0
  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    logic [3:0] a2;
    logic [3:0] a4;
    logic [3:0] a8;
    a2 = gf_mul(a, a);
    a4 = gf_mul(a2, a2);
    a8 = gf_mul(a4, a4);
    return gf_mul(gf_mul(a8, a4), a2);
  endfunction

  logic [2:0]  r_state;
  logic [4:0]  r_cnt;
  logic [14:0] r_rx;
  logic [14:0] r_word;
  logic [14:0] r_shift;
  logic [7:0]  r_par;
  logic [3:0]  r_s1;
  logic [3:0]  r_s3;
  logic [3:0]  r_t1;
  logic [3:0]  r_t2;
  logic [1:0]  r_deg;
  logic [3:0]  r_roots;
  logic [1:0]  r_status;

  logic        w_done;
  logic        w_fb;
  logic [7:0]  w_par_next;
  logic [3:0]  w_s1_next;
  logic [3:0]  w_s3_next;
  logic [3:0]  w_s1_cube;
  logic [3:0]  w_sigma2;
  logic        w_uncorr;
  logic        w_double;
  logic        w_chien_zero;
  logic [14:0] w_bit_mask;

  assign w_done     = (r_state == c_DONE);
  assign in_ready   = (r_state == c_IDLE);
  assign out_valid  = w_done;
  assign out_data   = w_done ? r_word   : 15'd0;
  assign out_status = w_done ? r_status : 2'b00;

  assign w_fb       = r_shift[14] ^ r_par[7];
  assign w_par_next = {r_par[6:0], 1'b0} ^ (w_fb ? GEN_POLY[7:0] : 8'h00);

  assign w_s1_next  = gf_mul(r_s1, c_ALPHA)  ^ {3'b000, r_shift[14]};
  assign w_s3_next  = gf_mul(r_s3, c_ALPHA3) ^ {3'b000, r_shift[14]};

  assign w_s1_cube  = gf_mul(gf_mul(r_s1, r_s1), r_s1);
  assign w_sigma2   = gf_mul(r_s3 ^ w_s1_cube, gf_inv(r_s1));
  assign w_uncorr   = (r_s1 == 4'd0) && (r_s3 != 4'd0);
  assign w_double   = (r_s1 != 4'd0) && (r_s3 != w_s1_cube);

  // sigma(a^-j) = 1 + S1*a^-j + sigma2*a^-2j, terms rotated once per cycle
  assign w_chien_zero = ((4'b0001 ^ r_t1 ^ r_t2) == 4'd0);
  assign w_bit_mask   = 15'd1 << r_cnt[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_cnt    <= 5'd0;
      r_rx     <= 15'd0;
      r_word   <= 15'd0;
      r_shift  <= 15'd0;
      r_par    <= 8'd0;
      r_s1     <= 4'd0;
      r_s3     <= 4'd0;
      r_t1     <= 4'd0;
      r_t2     <= 4'd0;
      r_deg    <= 2'd0;
      r_roots  <= 4'd0;
      r_status <= 2'b00;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_rx     <= in_data;
            r_word   <= in_data;
            r_shift  <= in_data;
            r_par    <= 8'd0;
            r_s1     <= 4'd0;
            r_s3     <= 4'd0;
            r_roots  <= 4'd0;
            r_status <= 2'b00;
            r_cnt    <= 5'd0;
            r_state  <= in_mode ? c_ENC : c_SYND;
          end
        end

        c_ENC: begin
          if (r_cnt == 5'd7) begin
            r_word  <= {r_rx[14:8], r_par};
            r_state <= c_DONE;
          end else begin
            r_par   <= w_par_next;
            r_shift <= {r_shift[13:0], 1'b0};
            r_cnt   <= r_cnt + 5'd1;
          end
        end

        c_SYND: begin
          r_s1    <= w_s1_next;
          r_s3    <= w_s3_next;
          r_shift <= {r_shift[13:0], 1'b0};
          if (r_cnt == 5'd14) begin
            r_cnt   <= 5'd0;
            r_state <= c_LOCATE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end

        c_LOCATE: begin
          if (w_uncorr) begin
            // Hold here so the overall latency matches the Chien path
            if (r_cnt == 5'd16) begin
              r_status <= c_ST_UNCORR;
              r_word   <= r_rx;
              r_state  <= c_DONE;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end else begin
            r_t1    <= r_s1;
            r_t2    <= w_double ? w_sigma2 : 4'd0;
            r_deg   <= (r_s1 == 4'd0) ? 2'd0 : (w_double ? 2'd2 : 2'd1);
            r_cnt   <= 5'd0;
            r_state <= c_CHIEN;
          end
        end

        c_CHIEN: begin
          if (r_cnt == 5'd15) begin
            if (r_roots == {2'b00, r_deg}) begin
              r_status <= r_deg;
            end else begin
              r_status <= c_ST_UNCORR;
              r_word   <= r_rx;
            end
            r_state <= c_DONE;
          end else begin
            if (w_chien_zero) begin
              r_word  <= r_word ^ w_bit_mask;
              r_roots <= r_roots + 4'd1;
            end
            r_t1  <= gf_mul(r_t1, c_ALPHA_INV);
            r_t2  <= gf_mul(r_t2, c_ALPHA_INV2);
            r_cnt <= r_cnt + 5'd1;
          end
        end

        c_DONE: begin
          if (out_ready) r_state <= c_IDLE;
        end

        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef BCH_ERR_COUNT_EN
  logic [7:0] r_err_cnt;

  // Encode results are always status 00, so only decodes can count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_done && out_ready && (r_status != 2'b00) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bch_decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bch_decode_sequencer
// Description : Randomised self-checking bench against a brute-force
//               nearest-codeword model of BCH(15,7,t=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bch_decode_sequencer;

  localparam logic [8:0] G = 9'b111010001;
`ifdef BCH_ERR_COUNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic [14:0] in_data = 15'd0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [14:0] out_data;
  logic [1:0]  out_status;
  logic [7:0]  err_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_err = 8'd0;

  bch_decode_sequencer #(.GEN_POLY(G)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_status(out_status),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Remainder of v(x) modulo G(x) by polynomial long division
  function automatic logic [7:0] poly_mod(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    for (int k = 14; k >= 8; k--)
      if (r[k]) r = r ^ ({6'd0, G} << (k - 8));
    return r[7:0];
  endfunction

  function automatic logic [14:0] model_encode(input logic [6:0] msg);
    return {msg, poly_mod({msg, 8'h00})};
  endfunction

  // Nearest codeword within distance 2, else report uncorrectable
  function automatic void model_decode(input logic [14:0] r, output logic [14:0] d,
                                       output logic [1:0] st);
    logic found;
    logic [14:0] t;
    d = r; st = 2'b11; found = 1'b0;
    if (poly_mod(r) == 8'h00) begin d = r; st = 2'b00; found = 1'b1; end
    for (int i = 0; i < 15; i++) begin
      t = r ^ (15'd1 << i);
      if (!found && poly_mod(t) == 8'h00) begin d = t; st = 2'b01; found = 1'b1; end
    end
    for (int i = 0; i < 15; i++)
      for (int j = i + 1; j < 15; j++) begin
        t = r ^ (15'd1 << i) ^ (15'd1 << j);
        if (!found && poly_mod(t) == 8'h00) begin d = t; st = 2'b10; found = 1'b1; end
      end
  endfunction

  // Presents one job, waits for the result and completes the handshake.
  task automatic run_job(input logic mode, input logic [14:0] data, output int lat,
                         output logic [14:0] d, output logic [1:0] st, output logic bad);
    bad = 1'b0;
    in_valid = 1'b1; in_mode = mode; in_data = data;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready !== 1'b0 || out_data !== 15'd0 || out_status !== 2'b00) bad = 1'b1;
      in_valid  = 1'($urandom);
      in_mode   = 1'($urandom);
      in_data   = 15'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    d = out_data; st = out_status;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    int lat; logic [14:0] d; logic [1:0] st; logic bad;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 15'd0 || out_status !== 2'b00) begin errors++; $display("FAIL rst_out: got %h/%b want 0/00", out_data, out_status); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    rst_n = 1'b1;
    exp_err = 8'd0;
    // First job presented in the first cycle after release; low bits must be ignored
    run_job(1'b1, {7'h01, 8'hA5}, lat, d, st, bad);
    checks++; if (d !== 15'h01D1 || st !== 2'b00) begin errors++; $display("FAIL first_encode: got %h/%b want 01d1/00", d, st); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL first_encode_lat: got %0d want 8", lat); end
  endtask

  task automatic test_vectors;
    logic [14:0] words [4];
    logic [14:0] want_d [4];
    logic [1:0]  want_s [4];
    int lat; logic [14:0] d; logic [1:0] st; logic bad;
    words[0] = 15'h01D1; want_d[0] = 15'h01D1; want_s[0] = 2'b00;
    words[1] = 15'h01D0; want_d[1] = 15'h01D1; want_s[1] = 2'b01;
    words[2] = 15'h41D9; want_d[2] = 15'h01D1; want_s[2] = 2'b10;
    words[3] = 15'h0013; want_d[3] = 15'h0013; want_s[3] = 2'b11;
    for (int n = 0; n < 4; n++) begin
      run_job(1'b0, words[n], lat, d, st, bad);
      if (ERR_EN && want_s[n] != 2'b00 && exp_err != 8'hFF) exp_err++;
      checks++; if (d !== want_d[n]) begin errors++; $display("FAIL vec%0d_data: got %h want %h", n, d, want_d[n]); end
      checks++; if (st !== want_s[n]) begin errors++; $display("FAIL vec%0d_status: got %b want %b", n, st, want_s[n]); end
      checks++; if (lat !== 32) begin errors++; $display("FAIL vec%0d_lat: got %0d want 32", n, lat); end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL vec%0d_busy_outputs: got %b want 0", n, bad); end
      checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL vec%0d_err_cnt: got %0d want %0d", n, err_cnt, exp_err); end
    end
  endtask

  task automatic test_random;
    int lat; logic [14:0] d; logic [1:0] st; logic bad;
    logic [6:0] msg; logic [14:0] word; logic [14:0] ed; logic [1:0] es;
    int nerr; int k;
    for (int n = 0; n < 12; n++) begin
      msg = 7'($urandom);
      run_job(1'b1, {msg, 8'($urandom)}, lat, d, st, bad);
      checks++; if (d !== model_encode(msg) || st !== 2'b00 || lat !== 8 || bad !== 1'b0) begin
        errors++; $display("FAIL rand_enc%0d: got %h/%b lat %0d bad %b want %h/00 lat 8 bad 0", n, d, st, lat, bad, model_encode(msg));
      end
    end
    for (int n = 0; n < 40; n++) begin
      word = model_encode(7'($urandom));
      nerr = $urandom_range(0, 3);
      for (int e = 0; e < nerr; e++) begin
        k = $urandom_range(0, 14);
        word[k] = ~word[k];
      end
      if ($urandom_range(0, 3) == 0) word = 15'($urandom);
      model_decode(word, ed, es);
      run_job(1'b0, word, lat, d, st, bad);
      if (ERR_EN && es != 2'b00 && exp_err != 8'hFF) exp_err++;
      checks++; if (d !== ed || st !== es) begin errors++; $display("FAIL rand_dec%0d: in %h got %h/%b want %h/%b", n, word, d, st, ed, es); end
      checks++; if (lat !== 32 || bad !== 1'b0) begin errors++; $display("FAIL rand_dec%0d_timing: lat %0d bad %b want 32/0", n, lat, bad); end
      checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL rand_dec%0d_err_cnt: got %0d want %0d", n, err_cnt, exp_err); end
    end
  endtask

  task automatic test_backpressure;
    logic [6:0] msg; logic [14:0] held; int lat; logic unstable;
    msg = 7'($urandom);
    in_valid = 1'b1; in_mode = 1'b1; in_data = {msg, 8'h00};
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 8) begin errors++; $display("FAIL bp_lat: got %0d want 8", lat); end
    held = out_data; unstable = 1'b0;
    // A competing job offered during DONE must be ignored
    in_valid = 1'b1; in_mode = 1'b0; in_data = 15'h7FFF;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== held || out_status !== 2'b00 || in_ready !== 1'b0) unstable = 1'b1;
    end
    checks++; if (held !== model_encode(msg)) begin errors++; $display("FAIL bp_data: got %h want %h", held, model_encode(msg)); end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL bp_stable: got %b want 0", unstable); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: in_ready %b out_valid %b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_midjob;
    int lat; logic [14:0] d; logic [1:0] st; logic bad;
    in_valid = 1'b1; in_mode = 1'b0; in_data = 15'h41D9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 15'd0) begin
      errors++; $display("FAIL midrst_async: in_ready %b out_valid %b out_data %h want 1/0/0", in_ready, out_valid, out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_err = 8'd0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || err_cnt !== exp_err) begin
      errors++; $display("FAIL midrst_release: in_ready %b out_valid %b err_cnt %0d want 1/0/0", in_ready, out_valid, err_cnt);
    end
    run_job(1'b1, {7'h01, 8'h00}, lat, d, st, bad);
    checks++; if (d !== 15'h01D1 || st !== 2'b00 || lat !== 8) begin
      errors++; $display("FAIL midrst_encode: got %h/%b lat %0d want 01d1/00 lat 8", d, st, lat);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_random();
    test_reset_midjob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
